// File: rtl/sram_lsu_master.sv
// sram_lsu_master
// Load/store access controller for a single-port 32-bit block SRAM. It takes
// byte-addressed load/store requests and turns them into word-addressed,
// byte-masked SRAM accesses. It returns exactly one response per request.
//
// Ports
//   clk, rst_n        clock (posedge) and synchronous active-low reset
//   req_*             request channel (valid/ready), sampled only on accept
//   rsp_*             response channel (valid/ready): load data or error flag
//   mem_*             SRAM side: cs, byte write enables, word address,
//                     write data, and read data (valid one cycle after a read)
//   dbg_state         current FSM state (0 IDLE, 1 ISSUE, 2 CAPT, 3 RESP)
//
// Handshake: a transfer happens on a posedge where valid & ready are both 1.
// A valid source holds its payload until the transfer. req_ready is 1 only in
// IDLE. rsp_valid is 1 only in RESP, and rsp_rdata/rsp_err are frozen there.
module sram_lsu_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      mem_cs,
  output logic [3:0]                mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                      accept;
  logic                      req_err;
  logic [ADDR_WIDTH-1:0]     hi_bits;
  logic [3:0]                st_mask;
  logic [31:0]               st_data;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;
  logic [31:0]               ld_ext;

  logic                      we_q;
  logic [1:0]                size_q;
  logic                      uns_q;
  logic [1:0]                lane_q;
  logic [3:0]                mask_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]               mem_wdata_q;
  logic [31:0]               rsp_rdata_q;
  logic                      rsp_err_q;

  assign accept = req_valid & req_ready;

  // Address bits above the SRAM's byte range must all be zero.
  assign hi_bits = req_addr >> (MEM_ADDR_WIDTH + 2);

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)                       req_err = 1'b1;
    if ((req_size == 2'b01) && req_addr[0])      req_err = 1'b1;
    if ((req_size == 2'b10) && (|req_addr[1:0])) req_err = 1'b1;
    if (|hi_bits)                                req_err = 1'b1;
  end

  // Store lane mask and replicated data. Replication puts the sub-word on
  // every lane, so only the mask depends on the low address bits.
  always_comb begin
    st_mask = 4'b1111;
    st_data = req_wdata;
    case (req_size)
      2'b00: begin
        st_mask = 4'b0001 << req_addr[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_mask = req_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = req_wdata;
      end
    endcase
  end

  // Load lane selection and extension, from the registered request fields.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (lane_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_ext  = mem_rdata;
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = req_err ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = we_q ? S_RESP : S_CAPT;
      S_CAPT:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    mem_cs    = (state_q == S_ISSUE);
    mem_we    = (state_q == S_ISSUE) ? mask_q : 4'b0000;
  end

  // Request capture and response data. Accept clears the response registers,
  // so stores and errors answer with rdata 0. A load overwrites rdata in CAPT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      mask_q      <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      rsp_err_q   <= req_err;
      rsp_rdata_q <= '0;
      if (!req_err) begin
        we_q       <= req_we;
        size_q     <= req_size;
        uns_q      <= req_unsigned;
        lane_q     <= req_addr[1:0];
        mask_q     <= req_we ? st_mask : 4'b0000;
        mem_addr_q <= req_addr[MEM_ADDR_WIDTH+1:2];
        if (req_we) mem_wdata_q <= st_data;
      end
    end else if (state_q == S_CAPT) begin
      rsp_rdata_q <= ld_ext;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_lsu_master.sv
module tb_sram_lsu_master;

  localparam int AW  = 32;
  localparam int MAW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           req_we = 1'b0;
  logic [1:0]     req_size = 2'b00;
  logic           req_unsigned = 1'b0;
  logic [AW-1:0]  req_addr = '0;
  logic [31:0]    req_wdata = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [31:0]    rsp_rdata;
  logic           rsp_err;
  logic           mem_cs;
  logic [3:0]     mem_we;
  logic [MAW-1:0] mem_addr;
  logic [31:0]    mem_wdata;
  logic [31:0]    mem_rdata = '0;
  logic [1:0]     dbg_state;

  sram_lsu_master #(.ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MAW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- SRAM model ----------------
  logic [31:0] sram [0:(1<<MAW)-1];

  always @(posedge clk) begin
    if (mem_cs) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= (mem_cs && mem_we == 4'b0000) ? sram[mem_addr] : 32'd0;
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];   // {err, rdata}
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata,
                              input logic [3:0] xwe, input logic [31:0] xwd);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_err = err; v.exp_rdata = rdata; v.exp_we = xwe; v.exp_wdata = xwd;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Entered just after a posedge. Drives one request, follows it to its
  // response, holds rsp_ready low for 'hold' response cycles, and returns
  // just after the posedge following consumption.
  task automatic run_req(input vec_t v, input int hold, input string tag);
    int          lat;
    int          cs_cnt;
    int          exp_lat;
    logic        seen;
    logic [32:0] exp;
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    rsp_ready = (hold == 0);
    exp_q.push_back({v.exp_err, v.exp_rdata});
    exp_lat = v.exp_err ? 1 : (v.we ? 2 : 3);
    @(negedge clk);
    chk({tag, " req_ready_idle"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    // Scramble the request fields after acceptance; the DUT must not care.
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom_range(0, 3)); req_we = 1'($urandom_range(0, 1));
    req_unsigned = 1'($urandom_range(0, 1));
    lat = 0; cs_cnt = 0; seen = 1'b0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (mem_cs) begin
        cs_cnt++;
        chk({tag, " cs_cycle"}, c, 1);
        chk({tag, " mem_we"}, {28'd0, mem_we}, {28'd0, v.exp_we});
        chk({tag, " mem_addr"}, {22'd0, mem_addr}, {22'd0, v.addr[MAW+1:2]});
        if (v.we) chk({tag, " mem_wdata"}, mem_wdata, v.exp_wdata);
      end
      if (rsp_valid) begin
        seen = 1'b1;
        lat = c;
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
    exp = exp_q.pop_front();
    if (seen) begin
      chk({tag, " rsp_err"}, {31'd0, rsp_err}, {31'd0, exp[32]});
      chk({tag, " rsp_rdata"}, rsp_rdata, exp[31:0]);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        if (h == hold - 1) rsp_ready = 1'b1;
        @(negedge clk);
        if (mem_cs) cs_cnt++;
        chk({tag, " hold_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, " hold_rdata"}, rsp_rdata, exp[31:0]);
        chk({tag, " hold_req_ready"}, {31'd0, req_ready}, 32'd0);
      end
      @(posedge clk); #1;
      @(negedge clk);
      if (mem_cs) cs_cnt++;
      chk({tag, " after_req_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, " after_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, " cs_count"}, cs_cnt, v.exp_err ? 0 : 1);
    rsp_ready = 1'b1;
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0]  = mk(1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 0, 32'h0,        4'hF, 32'hDEADBEEF);
    vecs[1]  = mk(1, 2'b00, 0, 32'h13,   32'h000000A5, 0, 32'h0,        4'h8, 32'hA5A5A5A5);
    vecs[2]  = mk(0, 2'b00, 0, 32'h13,   32'h0,        0, 32'hFFFFFFA5, 4'h0, 32'h0);
    vecs[3]  = mk(0, 2'b00, 1, 32'h13,   32'h0,        0, 32'h000000A5, 4'h0, 32'h0);
    vecs[4]  = mk(1, 2'b10, 0, 32'h10,   32'h80017F00, 0, 32'h0,        4'hF, 32'h80017F00);
    vecs[5]  = mk(0, 2'b01, 0, 32'h12,   32'h0,        0, 32'hFFFF8001, 4'h0, 32'h0);
    vecs[6]  = mk(0, 2'b01, 1, 32'h12,   32'h0,        0, 32'h00008001, 4'h0, 32'h0);
    vecs[7]  = mk(0, 2'b01, 0, 32'h10,   32'h0,        0, 32'h00007F00, 4'h0, 32'h0);
    vecs[8]  = mk(0, 2'b10, 0, 32'h10,   32'h0,        0, 32'h80017F00, 4'h0, 32'h0);
    vecs[9]  = mk(0, 2'b10, 0, 32'h02,   32'h0,        1, 32'h0,        4'h0, 32'h0);
    vecs[10] = mk(1, 2'b01, 0, 32'h05,   32'h12345678, 1, 32'h0,        4'h0, 32'h0);
    vecs[11] = mk(0, 2'b11, 0, 32'h20,   32'h0,        1, 32'h0,        4'h0, 32'h0);
    vecs[12] = mk(0, 2'b10, 0, 32'h1000, 32'h0,        1, 32'h0,        4'h0, 32'h0);
    vecs[13] = mk(1, 2'b00, 0, 32'h11,   32'h000001FF, 0, 32'h0,        4'h2, 32'hFFFFFFFF);
    vecs[14] = mk(0, 2'b00, 0, 32'h11,   32'h0,        0, 32'hFFFFFFFF, 4'h0, 32'h0);
    vecs[15] = mk(0, 2'b00, 1, 32'h11,   32'h0,        0, 32'h000000FF, 4'h0, 32'h0);
    vecs[16] = mk(1, 2'b10, 0, 32'h20,   32'h00000000, 0, 32'h0,        4'hF, 32'h00000000);
    vecs[17] = mk(1, 2'b01, 0, 32'h22,   32'h1234BEEF, 0, 32'h0,        4'hC, 32'hBEEFBEEF);
    vecs[18] = mk(0, 2'b00, 1, 32'h22,   32'h0,        0, 32'h000000EF, 4'h0, 32'h0);
    vecs[19] = mk(0, 2'b00, 0, 32'h23,   32'h0,        0, 32'hFFFFFFBE, 4'h0, 32'h0);
    vecs[20] = mk(0, 2'b01, 0, 32'h20,   32'h0,        0, 32'h00000000, 4'h0, 32'h0);
    vecs[21] = mk(1, 2'b10, 0, 32'hFFC,  32'h01020304, 0, 32'h0,        4'hF, 32'h01020304);
    vecs[22] = mk(0, 2'b10, 0, 32'hFFC,  32'h0,        0, 32'h01020304, 4'h0, 32'h0);
    vecs[23] = mk(0, 2'b01, 1, 32'hFFE,  32'h0,        0, 32'h00000102, 4'h0, 32'h0);
    vecs[24] = mk(0, 2'b10, 0, 32'h80000000, 32'h0,    1, 32'h0,        4'h0, 32'h0);
    vecs[25] = mk(1, 2'b10, 0, 32'h2000, 32'hCAFEF00D, 1, 32'h0,        4'h0, 32'h0);
    vecs[26] = mk(0, 2'b10, 1, 32'h10,   32'h0,        0, 32'h8001FF00, 4'h0, 32'h0);

    // reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset mem_cs", {31'd0, mem_cs}, 32'd0);
    chk("reset mem_we", {28'd0, mem_we}, 32'd0);
    chk("reset mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_req(vecs[i], 0, $sformatf("v%0d", i));

    // backpressure: response held for 5 cycles
    run_req(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h8001FF00, 4'h0, 32'h0), 5, "hold");

    // reset during CAPT drops the load
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'hFFC; req_valid = 1'b1;
    @(posedge clk); #1;            // accepted; now ISSUE
    req_valid = 1'b0;
    @(posedge clk); #1;            // now CAPT
    @(negedge clk);
    chk("rst_capt state", {30'd0, dbg_state}, 32'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_capt rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_capt req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_capt mem_cs", {31'd0, mem_cs}, 32'd0);
    chk("rst_capt rsp_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    run_req(mk(0, 2'b10, 0, 32'hFFC, 32'h0, 0, 32'h01020304, 4'h0, 32'h0), 0, "post_rst");

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_lsu_master.md
# sram_lsu_master

Initiator-side access controller for the single-port block SRAM model (cs / byte-we / word addr / wdata / registered rdata). Accepts byte-addressed load/store requests over a valid/ready handshake and converts them into the SRAM's word-addressed, byte-masked accesses. It performs lane alignment and byte replication for stores, and lane selection with sign or zero extension for loads. It also captures read data, which the SRAM presents for only one cycle, and returns one response per request. It sits between the core's memory stage and the data SRAM.

## Interface
- ADDR_WIDTH, 32, request byte-address width
- MEM_ADDR_WIDTH, 10, SRAM word-address width; the SRAM holds 2^MEM_ADDR_WIDTH 32-bit words
- Data width is fixed at 32 bits, with 4 byte lanes.

- clk  in  1  clock; all logic rises on posedge
- rst_n  in  1  reset; synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend loads (ignored for word and store)
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal size, or out of range
- mem_cs  out  1  SRAM chip select
- mem_we  out  4  SRAM byte write enables
- mem_addr  out  MEM_ADDR_WIDTH  SRAM word address (req_addr[MEM_ADDR_WIDTH+1:2])
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data; valid only in the cycle after a read select, 0 otherwise

## Operation
- FSM states:
  - IDLE: req_ready=1. On accept, the request is checked.
    - Error: go to RESP with rsp_err=1 and rsp_rdata=0. No SRAM access is made.
    - Otherwise: register the fields and go to ISSUE.
- Error conditions:
  - req_size=11.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Any bit of req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2] set.
- ISSUE: mem_cs=1 for exactly this cycle. mem_we is the store mask, or 0000 for a load. Next state is RESP for a store, CAPT for a load.
- CAPT: sample mem_rdata, extend it, register the result into rsp_rdata, go to RESP.
- RESP: rsp_valid=1. Stay until rsp_ready=1, then go to IDLE.
- Store lane mapping:
  - byte: mem_we = 0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - half: mem_we = addr[1] ? 1100 : 0011; mem_wdata = {2{wdata[15:0]}}.
  - word: mem_we = 1111; mem_wdata = wdata.
- Load extraction:
  - byte: lane addr[1:0] = mem_rdata[8*addr[1:0]+:8].
  - half: lane mem_rdata[16*addr[1]+:16].
  - Extend to 32 bits: sign-extend unless req_unsigned, which zero-extends.
- Outside ISSUE: mem_cs=0 and mem_we=0000. mem_addr and mem_wdata hold their last registered values.
- req_* fields are sampled only at acceptance; the requester may change them afterwards.
- rsp_rdata and rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset asserted in any state: on the next edge the FSM is in IDLE and any in-flight access or response is dropped. A write already issued in ISSUE is not undone.

## Timing
- Request accepted at edge T, meaning the request is present in cycle T.
- Store: mem_cs in cycle T+1; rsp_valid from cycle T+2.
- Load: mem_cs in cycle T+1; mem_rdata is valid in T+2 and captured at the end of T+2; rsp_valid from cycle T+3.
- Error: rsp_valid from cycle T+1; mem_cs is never asserted.
- Response consumed in cycle R: req_ready=1 from cycle R+1. There is no request/response overlap.
- Minimum spacing between accepted requests: loads 4 cycles, stores 3, errors 2.

## Test plan
- Store word 0xDEADBEEF to addr 0x10 -> T+1: mem_cs=1, mem_we=1111, mem_addr=4, mem_wdata=0xDEADBEEF; T+2: rsp_valid=1, rsp_err=0, rsp_rdata=0.
- Store byte 0x000000A5 to 0x13 -> mem_we=1000, mem_wdata=0xA5A5A5A5. Then lb 0x13 -> rsp_rdata=0xFFFFFFA5 at T+3; lbu 0x13 -> 0x000000A5.
- Store word 0x80017F00 to 0x10. Then:
  - lh 0x12 -> 0xFFFF8001
  - lhu 0x12 -> 0x00008001
  - lh 0x10 -> 0x00007F00
  - lw 0x10 -> 0x80017F00, with mem_we=0000 during ISSUE
- Error cases, each giving rsp_valid at T+1, rsp_err=1, rsp_rdata=0, and mem_cs never high:
  - lw 0x02
  - sh 0x05
  - req_size=11
  - lw 0x1000 with MEM_ADDR_WIDTH=10
- Load, then hold rsp_ready=0 for 5 cycles -> rsp_valid stays 1, rsp_rdata stays stable, req_ready=0, mem_cs high for exactly one cycle. The response is consumed on the first cycle rsp_ready=1, and req_ready=1 the next cycle.
- Assert rst_n=0 for one cycle during CAPT -> next cycle: rsp_valid=0, req_ready=1, mem_cs=0, rsp_rdata=0. A subsequent lw to a previously written address returns the correct data with normal latency.
